// File: rtl/color_sensor_sequencer_if.sv
// color_sensor_sequencer_if: sensor-side and sample-side signals of the RGB sequencer.
interface color_sensor_sequencer_if;
    logic       en;
    logic       sensor_out;
    logic       s2;
    logic       s3;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sample_valid;
    logic       busy;
    modport master (output en, sensor_out, input s2, s3, r, g, b, sample_valid, busy);
    modport slave  (input en, sensor_out, output s2, s3, r, g, b, sample_valid, busy);
endinterface

// File: rtl/color_sensor_sequencer.sv
// color_sensor_sequencer: cycles the sensor filter red/green/blue, counts sensor edges per
// window after a settle delay, and publishes the three counts together.
module color_sensor_sequencer #(
    parameter logic [15:0] SETTLE_CYCLES = 16'd1000,
    parameter logic [15:0] WINDOW_CYCLES = 16'd10000
) (
    input logic                     clk,
    input logic                     rst_n,
    color_sensor_sequencer_if.slave bus
);
    // A zero length behaves as one cycle.
    localparam logic [15:0] SETTLE_LAST = (SETTLE_CYCLES == 16'd0) ? 16'd0 : SETTLE_CYCLES - 16'd1;
    localparam logic [15:0] WIN_LAST    = (WINDOW_CYCLES == 16'd0) ? 16'd0 : WINDOW_CYCLES - 16'd1;

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d, filt_q, filt_d;
    logic [15:0] cyc_q, cyc_d;
    logic [7:0]  edges_q, edges_d, edges_inc;
    logic [7:0]  hold_r_q, hold_r_d, hold_g_q, hold_g_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        valid_q, valid_d;
    logic [2:0]  sync_q;
    logic        edge_det;

    assign edge_det  = sync_q[1] & ~sync_q[2];
    assign edges_inc = (edge_det && edges_q != 8'hFF) ? edges_q + 8'd1 : edges_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cyc_d    = cyc_q + 16'd1;
        edges_d  = edges_q;
        hold_r_d = hold_r_q;
        hold_g_d = hold_g_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        valid_d  = 1'b0;
        if (state_q == IDLE) begin
            cyc_d = 16'd0;
            if (bus.en) begin
                state_d = SETTLE;
                ch_d    = 2'd0;
            end
        end else if (!bus.en) begin
            state_d  = IDLE;
            ch_d     = 2'd0;
            cyc_d    = 16'd0;
            edges_d  = 8'd0;
            hold_r_d = 8'd0;
            hold_g_d = 8'd0;
        end else if (state_q == SETTLE) begin
            if (cyc_q == SETTLE_LAST) begin
                state_d = COUNT;
                cyc_d   = 16'd0;
                edges_d = 8'd0;
            end
        end else if (state_q == COUNT) begin
            edges_d = edges_inc;
            if (cyc_q == WIN_LAST) begin
                state_d  = SETTLE;
                cyc_d    = 16'd0;
                ch_d     = (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
                hold_r_d = (ch_q == 2'd0) ? edges_inc : hold_r_q;
                hold_g_d = (ch_q == 2'd1) ? edges_inc : hold_g_q;
                if (ch_q == 2'd2) begin
                    r_d     = hold_r_q;
                    g_d     = hold_g_q;
                    b_d     = edges_inc;
                    valid_d = 1'b1;
                end
            end
        end else begin
            state_d = IDLE;
        end
        filt_d = (state_d == IDLE) ? 2'b10 :
                 (ch_d == 2'd0)    ? 2'b00 :
                 (ch_d == 2'd1)    ? 2'b11 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            filt_q   <= 2'b10;
            cyc_q    <= 16'd0;
            edges_q  <= 8'd0;
            hold_r_q <= 8'd0;
            hold_g_q <= 8'd0;
            r_q      <= 8'd0;
            g_q      <= 8'd0;
            b_q      <= 8'd0;
            valid_q  <= 1'b0;
            sync_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            filt_q   <= filt_d;
            cyc_q    <= cyc_d;
            edges_q  <= edges_d;
            hold_r_q <= hold_r_d;
            hold_g_q <= hold_g_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            sync_q   <= {sync_q[1:0], bus.sensor_out};
        end
    end

    assign bus.s2           = filt_q[1];
    assign bus.s3           = filt_q[0];
    assign bus.r            = r_q;
    assign bus.g            = g_q;
    assign bus.b            = b_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_color_sensor_sequencer.sv
// tb_color_sensor_sequencer: directed checks of the RGB sequencer with short settle/window
// lengths, plus a long-window instance for count saturation.
module tb_color_sensor_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    color_sensor_sequencer_if u_if();
    color_sensor_sequencer_if s_if();

    color_sensor_sequencer #(.SETTLE_CYCLES(16'd4), .WINDOW_CYCLES(16'd16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(u_if));
    color_sensor_sequencer #(.SETTLE_CYCLES(16'd4), .WINDOW_CYCLES(16'd1024)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(s_if));

    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    int   sv_q[$];
    int   busy_drop = 0;
    bit   mon_busy = 1'b0;
    int   e0, sz;
    bit   found;
    logic pin [0:179];
    int   n_pulses [3] = '{3, 5, 7};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.sample_valid) sv_q.push_back(cyc);
        if (mon_busy && !u_if.busy) busy_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Iteration k drives pin[k] just after start edge + k, then waits for the next edge.
    task automatic run(input int from, input int to);
        for (int k = from; k < to; k++) begin
            #1 u_if.sensor_out = pin[k];
            @(posedge clk);
        end
    endtask

    task automatic fill_toggle();
        for (int k = 0; k < 180; k++) pin[k] = (k % 2 == 0);
    endtask

    task automatic start();
        @(negedge clk);
        u_if.en = 1'b1;
        e0 = cyc + 1;
        @(posedge clk);
    endtask

    initial begin
        u_if.en = 1'b0; u_if.sensor_out = 1'b0;
        s_if.en = 1'b0; s_if.sensor_out = 1'b0;
        #1 rst_n = 1'b0;
        #20;
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_s2s3", {u_if.s2, u_if.s3}, 2'b10);
        chk("rst_rgb", {u_if.r, u_if.g, u_if.b}, 24'h0);
        chk("rst_valid", u_if.sample_valid, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_en", u_if.busy, 1'b0);

        // Steady toggling: 8 edges per 16-cycle window.
        fill_toggle();
        start();
        run(0, 10);
        #1 chk("red_s2s3", {u_if.s2, u_if.s3}, 2'b00);
        chk("red_busy", u_if.busy, 1'b1);
        run(10, 30);
        #1 chk("green_s2s3", {u_if.s2, u_if.s3}, 2'b11);
        run(30, 50);
        #1 chk("blue_s2s3", {u_if.s2, u_if.s3}, 2'b01);
        run(50, 59);
        #1 chk("valid_early", u_if.sample_valid, 1'b0);
        run(59, 60);
        #1 chk("steady_valid", u_if.sample_valid, 1'b1);
        chk("steady_rgb", {u_if.r, u_if.g, u_if.b}, 24'h080808);
        chk("next_red_s2s3", {u_if.s2, u_if.s3}, 2'b00);
        u_if.sensor_out = 1'b0; u_if.en = 1'b0;
        @(posedge clk); #1;
        chk("stop_busy", u_if.busy, 1'b0);
        chk("stop_s2s3", {u_if.s2, u_if.s3}, 2'b10);
        chk("valid_width", u_if.sample_valid, 1'b0);
        @(negedge clk);
        chk("steady_pulses", sv_q.size(), 1);
        chk("steady_latency", sv_q[0] - e0, 60);

        // Distinct counts per channel, with pulses in the settle periods that must be ignored.
        for (int k = 0; k < 180; k++) pin[k] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) pin[20*c - 2] = 1'b1;
            pin[20*c] = 1'b1;
            for (int i = 0; i < n_pulses[c]; i++) pin[20*c + 4 + 2*i] = 1'b1;
        end
        start();
        run(0, 60);
        #1 chk("distinct_valid", u_if.sample_valid, 1'b1);
        chk("distinct_r", u_if.r, 8'h03);
        chk("distinct_g", u_if.g, 8'h05);
        chk("distinct_b", u_if.b, 8'h07);
        u_if.sensor_out = 1'b0; u_if.en = 1'b0;
        @(posedge clk); #1;
        chk("distinct_idle", u_if.busy, 1'b0);

        // Abort during the green window.
        fill_toggle();
        @(negedge clk) sz = sv_q.size();
        start();
        run(0, 30);
        #1 u_if.en = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", u_if.busy, 1'b0);
        chk("abort_s2s3", {u_if.s2, u_if.s3}, 2'b10);
        chk("abort_rgb", {u_if.r, u_if.g, u_if.b}, 24'h030507);
        chk("abort_valid", u_if.sample_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_pulses", sv_q.size() - sz, 0);
        u_if.sensor_out = 1'b0;

        // Continuous run of three samples.
        @(negedge clk) sz = sv_q.size();
        start();
        run(0, 1);
        mon_busy = 1'b1;
        run(1, 180);
        @(negedge clk); #1;
        mon_busy = 1'b0;
        chk("cont_pulses", sv_q.size() - sz, 3);
        chk("cont_first", sv_q[sz] - e0, 60);
        chk("cont_gap1", sv_q[sz+1] - sv_q[sz], 60);
        chk("cont_gap2", sv_q[sz+2] - sv_q[sz+1], 60);
        chk("cont_busy_drops", busy_drop, 0);
        chk("cont_rgb", {u_if.r, u_if.g, u_if.b}, 24'h080808);

        // Asynchronous reset in the middle of a red window.
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", u_if.busy, 1'b0);
        chk("arst_s2s3", {u_if.s2, u_if.s3}, 2'b10);
        chk("arst_rgb", {u_if.r, u_if.g, u_if.b}, 24'h0);
        chk("arst_valid", u_if.sample_valid, 1'b0);
        u_if.en = 1'b0; u_if.sensor_out = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) u_if.en = 1'b1;
        @(posedge clk); #1;
        chk("restart_busy", u_if.busy, 1'b1);
        chk("restart_s2s3", {u_if.s2, u_if.s3}, 2'b00);
        u_if.en = 1'b0;

        // Saturation with 1024-cycle windows.
        found = 1'b0;
        @(negedge clk) s_if.en = 1'b1;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(posedge clk);
            #1 s_if.sensor_out = ~s_if.sensor_out;
            found = s_if.sample_valid;
        end
        chk("sat_valid_seen", found, 1'b1);
        chk("sat_r", s_if.r, 8'hFF);
        chk("sat_g", s_if.g, 8'hFF);
        chk("sat_b", s_if.b, 8'hFF);
        s_if.en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
